// File: rtl/mad_multicycle_pool.sv
// Pool of COUNT multicycle multiply-add slots, O = C +/- A*B, issued round-robin and drained in order.
// Latency: operands accepted at edge t give OE=1 in the cycle after edge t+CYCLE (earliest).
// Backpressure: IREADY drops when the next issue slot is still busy/undrained; OE/O hold while OREADY=0.
module mad_multicycle_pool #(
  parameter int WIDTH = 64,
  parameter int CYCLE = 3,
  parameter int COUNT = 2,
  parameter int PW    = $clog2(COUNT + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IE,
  output logic             IREADY,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic             OE,
  input  logic             OREADY,
  output logic [WIDTH-1:0] O,
  output logic [PW-1:0]    PENDING
);

  localparam int IW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int CW = (CYCLE > 1) ? $clog2(CYCLE) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IW-1:0] LAST_SLOT = IW'(COUNT - 1);
  localparam logic [CW-1:0] CNT_INIT  = CW'(CYCLE - 1);

  logic [1:0]       state_q [COUNT];
  logic [CW-1:0]    cnt_q   [COUNT];
  logic [WIDTH-1:0] a_q     [COUNT];
  logic [WIDTH-1:0] b_q     [COUNT];
  logic [WIDTH-1:0] c_q     [COUNT];
  logic             sub_q   [COUNT];
  logic [WIDTH-1:0] res_q   [COUNT];
  logic [WIDTH-1:0] mad_res [COUNT];

  logic [IW-1:0]    issue_ptr;
  logic [IW-1:0]    out_ptr;
  logic [PW-1:0]    pend_q;

  logic             accept;
  logic             drain;
  logic [COUNT-1:0] fill;
  logic [COUNT-1:0] empty;

  // Handshake decode: the issue slot is free if idle, or if it is the head result being drained this cycle.
  always_comb begin
    IREADY = (state_q[issue_ptr] == S_IDLE) ||
             ((state_q[issue_ptr] == S_DONE) && (out_ptr == issue_ptr) && OREADY);
    OE     = (state_q[out_ptr] == S_DONE);
    O      = OE ? res_q[out_ptr] : '0;
    accept = IE && IREADY;
    drain  = OE && OREADY;
    for (int i = 0; i < COUNT; i++) begin
      fill[i]  = accept && (issue_ptr == IW'(i));
      empty[i] = drain && (out_ptr == IW'(i));
    end
  end

  // Per-slot arithmetic from the stable operand latches; timed as a CYCLE-clock multicycle path.
  always_comb begin
    for (int i = 0; i < COUNT; i++) begin
      mad_res[i] = sub_q[i] ? (c_q[i] - a_q[i] * b_q[i]) : (c_q[i] + a_q[i] * b_q[i]);
    end
  end

  // Slot state machines: latch operands on fill, count down while busy, capture result, free on drain.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < COUNT; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        res_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < COUNT; i++) begin
        case (state_q[i])
          S_IDLE: begin
            if (fill[i]) begin
              state_q[i] <= S_BUSY;
              cnt_q[i]   <= CNT_INIT;
              a_q[i]     <= A;
              b_q[i]     <= B;
              c_q[i]     <= C;
              sub_q[i]   <= SUB;
            end
          end
          S_BUSY: begin
            if (cnt_q[i] == '0) begin
              state_q[i] <= S_DONE;
              res_q[i]   <= mad_res[i];
            end else begin
              cnt_q[i] <= cnt_q[i] - CW'(1);
            end
          end
          S_DONE: begin
            if (empty[i]) begin
              if (fill[i]) begin
                state_q[i] <= S_BUSY;
                cnt_q[i]   <= CNT_INIT;
                a_q[i]     <= A;
                b_q[i]     <= B;
                c_q[i]     <= C;
                sub_q[i]   <= SUB;
              end else begin
                state_q[i] <= S_IDLE;
              end
            end
          end
          default: state_q[i] <= S_IDLE;
        endcase
      end
    end
  end

  // Round-robin issue and drain pointers, wrapping at COUNT.
  always_ff @(posedge CLK) begin
    if (RST) begin
      issue_ptr <= '0;
      out_ptr   <= '0;
    end else begin
      if (accept) begin
        issue_ptr <= (issue_ptr == LAST_SLOT) ? '0 : issue_ptr + IW'(1);
      end
      if (drain) begin
        out_ptr <= (out_ptr == LAST_SLOT) ? '0 : out_ptr + IW'(1);
      end
    end
  end

  // Occupancy count: slots holding an in-flight or undrained result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_q <= '0;
    end else begin
      case ({accept, drain})
        2'b10:   pend_q <= pend_q + PW'(1);
        2'b01:   pend_q <= pend_q - PW'(1);
        default: pend_q <= pend_q;
      endcase
    end
  end

  assign PENDING = pend_q;

endmodule
